// File: rtl/viterbi_ber_monitor.sv
// viterbi_ber_monitor
// Bit-error-rate monitor placed after the Viterbi decoder. Every information
// bit entering the encoder is stored in a reference FIFO. Each decoded bit pops
// one reference bit and compares it with the decoded bit. The first SKIP_BITS
// pops after start/clear cover the decoder warm-up and are discarded. After that
// the monitor counts compared bits and mismatches, both saturating.
//
// Optional build macro BER_BURST_EN adds max_burst_o, the longest run of
// consecutive mismatches seen in TRACK (saturates at 255).
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE (0) | waiting for the first successful pop after reset/clear
// SKIP (1) | decoder warm-up, pops are consumed but not compared
// TRACK(2) | every successful pop is compared and counted

module viterbi_ber_monitor #(
   parameter int DEPTH     = 64,
   parameter int CNT_W     = 16,
   parameter int SKIP_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ref_bit_i,
   input  logic                     ref_valid_i,
   input  logic                     dec_bit_i,
   input  logic                     dec_valid_i,
   input  logic                     clear_i,
   output logic [1:0]               state_o,
   output logic                     err_o,
   output logic [CNT_W-1:0]         bit_cnt_o,
   output logic [CNT_W-1:0]         err_cnt_o,
   output logic [$clog2(DEPTH):0]   fifo_level_o,
   output logic                     overflow_o,
   output logic                     underflow_o
`ifdef BER_BURST_EN
   ,
   output logic [7:0]               max_burst_o
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int SKIP_W = $clog2(SKIP_BITS + 2);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SKIP  = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   // skip_cnt holds the number of warm-up pops already taken, so the pop that
   // sees this value is the last one discarded
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic              mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;

   logic [1:0]        state_q, state_d;
   logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;

   logic              err_q, err_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic              full, empty, push, pop;
   logic              ref_bit, mismatch, count_en;

`ifdef BER_BURST_EN
   logic [7:0]        run_q, run_d;
   logic [7:0]        max_burst_q, max_burst_d;
   logic [7:0]        run_next;
`endif

   // FIFO handshake and pointer/occupancy next values; a pop on a full FIFO
   // frees the slot for a push in the same cycle, an empty FIFO never bypasses
   always_comb begin
      full     = (level_q == LVL_FULL);
      empty    = (level_q == '0);
      pop      = dec_valid_i && !empty;
      push     = ref_valid_i && (!full || pop);
      ref_bit  = mem_q[rd_ptr_q];
      mismatch = ref_bit ^ dec_bit_i;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   // Reference bit storage; contents are meaningless once the pointers reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= ref_bit_i;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         skip_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   // FSM next state: only successful pops advance the warm-up sequence
   always_comb begin
      state_d    = state_q;
      skip_cnt_d = skip_cnt_q;
      if (clear_i) begin
         state_d    = ST_IDLE;
         skip_cnt_d = '0;
      end else if (pop) begin
         case (state_q)
            ST_IDLE: begin
               if (SKIP_BITS <= 1) begin
                  state_d = ST_TRACK;
               end else begin
                  state_d    = ST_SKIP;
                  skip_cnt_d = SKIP_W'(1);
               end
            end
            ST_SKIP: begin
               if (skip_cnt_q == SKIP_LAST) begin
                  state_d = ST_TRACK;
               end else begin
                  skip_cnt_d = skip_cnt_q + 1'b1;
               end
            end
            ST_TRACK: state_d = ST_TRACK;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs and counter/flag next values; clear wins over counting
   always_comb begin
      count_en  = pop && !clear_i &&
                  ((state_q == ST_TRACK) || ((state_q == ST_IDLE) && (SKIP_BITS == 0)));
      err_d     = 1'b0;
      bit_cnt_d = bit_cnt_q;
      err_cnt_d = err_cnt_q;
      ovf_d     = ovf_q || (ref_valid_i && !push);
      unf_d     = unf_q || (dec_valid_i && empty);
      if (clear_i) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end else if (count_en) begin
         if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
         if (mismatch) begin
            err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
         end
      end
   end

`ifdef BER_BURST_EN
   // Burst tracking: run of consecutive counted mismatches and its maximum
   always_comb begin
      run_d       = run_q;
      max_burst_d = max_burst_q;
      run_next    = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
      if (clear_i) begin
         run_d       = '0;
         max_burst_d = '0;
      end else if (count_en) begin
         if (mismatch) begin
            run_d = run_next;
            if (run_next > max_burst_q) begin
               max_burst_d = run_next;
            end
         end else begin
            run_d = '0;
         end
      end
   end

   // Burst registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q       <= '0;
         max_burst_q <= '0;
      end else begin
         run_q       <= run_d;
         max_burst_q <= max_burst_d;
      end
   end

   // Burst output
   always_comb begin
      max_burst_o = max_burst_q;
   end
`endif

   // FIFO pointers, occupancy, counters and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         err_q     <= 1'b0;
         bit_cnt_q <= '0;
         err_cnt_q <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         err_q     <= err_d;
         bit_cnt_q <= bit_cnt_d;
         err_cnt_q <= err_cnt_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Registered outputs
   always_comb begin
      state_o      = state_q;
      err_o        = err_q;
      bit_cnt_o    = bit_cnt_q;
      err_cnt_o    = err_cnt_q;
      fifo_level_o = level_q;
      overflow_o   = ovf_q;
      underflow_o  = unf_q;
   end

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Bench for viterbi_ber_monitor: default instance (DEPTH 64, CNT_W 16,
// SKIP_BITS 8) plus a small-counter instance (CNT_W 4, SKIP_BITS 0) for
// saturation. A queue-based reference model is compared every cycle, and
// directed scenarios pin hand-computed values.

module tb_viterbi_ber_monitor;

   bit clk = 1'b0;
   bit rst = 1'b0;
   always #5 clk = ~clk;

   logic rv = 0, rb = 0, dv = 0, db = 0, clr = 0;
   logic s_rv = 0, s_rb = 0, s_dv = 0, s_db = 0;

   logic [1:0]  st0, st1;
   logic        err0, err1;
   logic [15:0] bc0, ec0;
   logic [3:0]  bc1, ec1;
   logic [6:0]  lv0, lv1;
   logic        ov0, ov1, un0, un1;
   logic [7:0]  mb0, mb1;

   viterbi_ber_monitor #(.DEPTH(64), .CNT_W(16), .SKIP_BITS(8)) dut (
      .clk(clk), .rst(rst),
      .ref_bit_i(rb), .ref_valid_i(rv), .dec_bit_i(db), .dec_valid_i(dv), .clear_i(clr),
      .state_o(st0), .err_o(err0), .bit_cnt_o(bc0), .err_cnt_o(ec0),
      .fifo_level_o(lv0), .overflow_o(ov0), .underflow_o(un0)
`ifdef BER_BURST_EN
      , .max_burst_o(mb0)
`endif
   );

   viterbi_ber_monitor #(.DEPTH(64), .CNT_W(4), .SKIP_BITS(0)) dut_s (
      .clk(clk), .rst(rst),
      .ref_bit_i(s_rb), .ref_valid_i(s_rv), .dec_bit_i(s_db), .dec_valid_i(s_dv), .clear_i(1'b0),
      .state_o(st1), .err_o(err1), .bit_cnt_o(bc1), .err_cnt_o(ec1),
      .fifo_level_o(lv1), .overflow_o(ov1), .underflow_o(un1)
`ifdef BER_BURST_EN
      , .max_burst_o(mb1)
`endif
   );

`ifndef BER_BURST_EN
   assign mb0 = 8'd0;
   assign mb1 = 8'd0;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;
   bit s_done = 0;
   int n_err0 = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit pat(input int i);
      return ((i * 5 + 3) % 7) > 3;
   endfunction

   // Reference model: queue of reference bits, count of pops since start/clear
   bit mq [2][$];
   int m_pops [2];
   int m_bits [2];
   int m_errs [2];
   int m_run  [2];
   int m_max  [2];
   bit m_err  [2];
   bit m_ovf  [2];
   bit m_unf  [2];

   function automatic int skipb(input int k);
      return (k == 0) ? 8 : 0;
   endfunction

   function automatic int cmax(input int k);
      return (k == 0) ? 65535 : 15;
   endfunction

   function automatic int model_state(input int k);
      if (m_pops[k] == 0) return 0;
      if (m_pops[k] < skipb(k)) return 1;
      return 2;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         m_pops[k] = 0; m_bits[k] = 0; m_errs[k] = 0; m_run[k] = 0; m_max[k] = 0;
         m_err[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input bit r_v, input bit r_b, input bit d_v,
                             input bit d_b, input bit c);
      bit pop_ok, push_ok, r, counted;
      pop_ok  = d_v && (mq[k].size() > 0);
      push_ok = r_v && ((mq[k].size() < 64) || pop_ok);
      r = 0;
      if (pop_ok) r = mq[k].pop_front();
      if (push_ok) mq[k].push_back(r_b);
      m_err[k] = 0;
      if (c) begin
         m_pops[k] = 0; m_bits[k] = 0; m_errs[k] = 0; m_run[k] = 0; m_max[k] = 0;
         m_ovf[k] = 0; m_unf[k] = 0;
      end else begin
         if (r_v && !push_ok) m_ovf[k] = 1;
         if (d_v && !pop_ok)  m_unf[k] = 1;
         if (pop_ok) begin
            counted = (m_pops[k] >= skipb(k));
            if (m_pops[k] < 1000000) m_pops[k]++;
            if (counted) begin
               if (m_bits[k] < cmax(k)) m_bits[k]++;
               if (r != d_b) begin
                  m_err[k] = 1;
                  if (m_errs[k] < cmax(k)) m_errs[k]++;
                  if (m_run[k] < 255) m_run[k]++;
                  if (m_run[k] > m_max[k]) m_max[k] = m_run[k];
               end else begin
                  m_run[k] = 0;
               end
            end
         end
      end
   endtask

   // Model advances on the same edges as the DUT
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         model_step(0, rv, rb, dv, db, clr);
         model_step(1, s_rv, s_rb, s_dv, 1'b0 ^ s_db, 1'b0);
      end
   end

   task automatic cmp(input int k, input int st, input int e, input int bc, input int ec,
                      input int lv, input int ov, input int un, input int mb);
      chk($sformatf("state%0d", k), st, model_state(k));
      chk($sformatf("err_o%0d", k), e, int'(m_err[k]));
      chk($sformatf("bit_cnt%0d", k), bc, m_bits[k]);
      chk($sformatf("err_cnt%0d", k), ec, m_errs[k]);
      chk($sformatf("level%0d", k), lv, mq[k].size());
      chk($sformatf("overflow%0d", k), ov, int'(m_ovf[k]));
      chk($sformatf("underflow%0d", k), un, int'(m_unf[k]));
`ifdef BER_BURST_EN
      chk($sformatf("max_burst%0d", k), mb, m_max[k]);
`endif
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, st0, err0, bc0, ec0, lv0, ov0, un0, mb0);
         cmp(1, st1, err1, bc1, ec1, lv1, ov1, un1, mb1);
         if (err0) n_err0++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Saturation scenario on the CNT_W=4 instance: 20 mismatching compares
   initial begin
      @(negedge rst);
      for (int i = 0; i <= 20; i++) begin
         s_rv = (i < 20);
         s_rb = pat(i);
         s_dv = (i > 0);
         s_db = !pat(i - 1);
         tick();
      end
      s_rv = 0; s_dv = 0;
      tick();
      chk("sat_bit_cnt", bc1, 15);
      chk("sat_err_cnt", ec1, 15);
      chk("sat_state", st1, 2);
`ifdef BER_BURST_EN
      chk("sat_max_burst", mb1, 20);
`endif
      s_done = 1;
   end

   initial begin
      #1 rst = 1;
      repeat (3) tick();
      rst = 0;
      chk_en = 1;
      chk("rst_state", st0, 0);
      chk("rst_level", lv0, 0);
      chk("rst_bit_cnt", bc0, 0);
      chk("rst_flags", {ov0, un0, err0}, 0);

      // clean loopback, decoder delayed by 20 cycles
      for (int t = 0; t < 220; t++) begin
         rv = (t < 200); rb = pat(t);
         dv = (t >= 20); db = pat(t - 20);
         tick();
         if (t == 22) chk("skip_state", st0, 1);
      end
      rv = 0; dv = 0;
      chk("clean_bit_cnt", bc0, 192);
      chk("clean_err_cnt", ec0, 0);
      chk("clean_state", st0, 2);
      chk("clean_flags", {ov0, un0}, 0);

      // three injected errors at TRACK positions 10, 11, 50
      clr = 1; tick(); clr = 0;
      n_err0 = 0;
      for (int t = 0; t < 120; t++) begin
         int p;
         p = t - 20;
         rv = (t < 100); rb = pat(t + 3);
         dv = (t >= 20); db = pat(p + 3) ^ ((p == 18) || (p == 19) || (p == 58));
         tick();
      end
      rv = 0; dv = 0;
      tick();
      chk("inj_err_cnt", ec0, 3);
      chk("inj_bit_cnt", bc0, 92);
      chk("inj_pulses", n_err0, 3);
`ifdef BER_BURST_EN
      chk("inj_max_burst", mb0, 2);
`endif

      // overflow, then push+pop while full
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 64; i++) begin
         rv = 1; rb = pat(i); tick();
      end
      chk("full_level", lv0, 64);
      chk("full_no_ovf", ov0, 0);
      rv = 1; rb = 1; tick();
      chk("ovf_set", ov0, 1);
      chk("ovf_level", lv0, 64);
      rv = 1; rb = 0; dv = 1; db = pat(0); tick();
      chk("pushpop_full_level", lv0, 64);
      rv = 0;
      for (int i = 0; i < 64; i++) begin
         dv = 1; db = pat(i + 1); tick();
      end
      dv = 0;
      chk("drain_level", lv0, 0);
      chk("ovf_sticky", ov0, 1);

      // underflow, push+pop on empty, then a normal pop
      clr = 1; tick(); clr = 0;
      dv = 1; tick(); dv = 0;
      chk("unf_set", un0, 1);
      chk("unf_counts", bc0 + ec0, 0);
      chk("unf_level", lv0, 0);
      rv = 1; rb = 1; dv = 1; db = 1; tick();
      chk("pushpop_empty_level", lv0, 1);
      rv = 0; dv = 1; db = 1; tick(); dv = 0;
      chk("unf_pop_level", lv0, 0);
      chk("unf_pop_state", st0, 1);

      // reach TRACK with 5 bits left, then clear
      for (int i = 0; i < 20; i++) begin
         rv = 1; rb = pat(i); tick();
      end
      rv = 0;
      for (int i = 0; i < 15; i++) begin
         dv = 1; db = pat(i); tick();
      end
      dv = 0;
      chk("pre_clr_bit_cnt", bc0, 8);
      chk("pre_clr_state", st0, 2);
      chk("pre_clr_level", lv0, 5);
      clr = 1; tick(); clr = 0;
      chk("clr_state", st0, 0);
      chk("clr_counts", bc0 + ec0, 0);
      chk("clr_flags", {ov0, un0, err0}, 0);
      chk("clr_level", lv0, 5);

      // mismatching stream, then asynchronous reset mid-cycle
      for (int i = 0; i < 10; i++) begin
         rv = 1; rb = pat(20 + i);
         dv = 1; db = !pat(15 + i);
         tick();
      end
      chk("pre_rst_bit_cnt", bc0, 2);
      chk("pre_rst_err_o", err0, 1);
      chk("pre_rst_level", lv0, 5);
      #2 rst = 1;
      #1;
      chk("arst_state", st0, 0);
      chk("arst_err_o", err0, 0);
      chk("arst_counts", bc0 + ec0, 0);
      chk("arst_level", lv0, 0);
      rv = 0; dv = 0;
      tick(); tick();
      rst = 0;
      tick();

      for (int i = 0; i < 1000 && !s_done; i++) tick();
      chk("sat_done", int'(s_done), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/viterbi_ber_monitor.md
Name: viterbi_ber_monitor

Overview:
Bit-error-rate monitor directly downstream of the Viterbi decoder in the tx/rx loopback. Buffers every information bit entering the convolutional encoder in a reference FIFO, pops one per decoded output bit, compares, and accumulates bit/error counts. Discards a configurable decoder warm-up window before counting. Provides per-bit error pulses and saturating counters for the error-injection benches.

Parameters:
DEPTH, 64, reference FIFO depth in bits; power of 2, >= decoder latency + margin
CNT_W, 16, width of bit/error counters
SKIP_BITS, 8, decoded bits discarded after start/clear before counting (0 = none)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
ref_bit_i  input  1  information bit presented to the encoder
ref_valid_i  input  1  ref_bit_i valid this cycle; push to FIFO
dec_bit_i  input  1  decoded bit from the Viterbi decoder
dec_valid_i  input  1  dec_bit_i valid this cycle; pop and compare
clear_i  input  1  synchronous clear of counters, flags and FSM
state_o  output  2  FSM state: 0 IDLE, 1 SKIP, 2 TRACK
err_o  output  1  one-cycle pulse: compared bit mismatched (TRACK only)
bit_cnt_o  output  CNT_W  bits compared in TRACK, saturating
err_cnt_o  output  CNT_W  mismatches in TRACK, saturating
fifo_level_o  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow_o  output  1  sticky: push dropped while full
underflow_o  output  1  sticky: pop requested while empty

Behaviour:
- Reset (rst=1, async): FIFO empty, pointers 0, state IDLE, err_o=0, bit_cnt_o=0, err_cnt_o=0, fifo_level_o=0, overflow_o=0, underflow_o=0.
- FIFO: write pointer/read pointer of $clog2(DEPTH) bits wrapping modulo DEPTH; occupancy counter separate. Push when ref_valid_i && !full; pop when dec_valid_i && !empty.
- Simultaneous push+pop: always allowed, including when full (pop frees slot same cycle) and when empty (pop sees underflow; push still lands, no bypass). Level unchanged when both succeed.
- Push while full with no pop: bit dropped, overflow_o set. Pop while empty: no compare, no count, underflow_o set.
- Compare: popped reference bit XOR dec_bit_i; result registered: err_o, counters updated on the clock edge after dec_valid_i (latency 1 cycle).
- FSM:
  IDLE -> first successful pop: if SKIP_BITS==0 go TRACK and that pop is counted, else go SKIP with skip counter = 1.
  SKIP: each successful pop increments skip counter, not compared/counted; when the SKIP_BITS-th pop occurs -> TRACK next cycle.
  TRACK: every successful pop increments bit_cnt_o; mismatch increments err_cnt_o and pulses err_o. Stays until clear_i or rst.
- Saturation: bit_cnt_o and err_cnt_o stop at 2^CNT_W-1; no wrap.
- clear_i: next edge zeroes counters, overflow_o, underflow_o, err_o; state -> IDLE; FIFO contents and pointers preserved (alignment kept). A pop in the clear cycle is consumed but not counted. clear_i has priority over counting.
- Reset mid-operation discards all FIFO contents; bench must re-prime.

Optional Feature:
BER_BURST_EN: adds output max_burst_o (width 8) and internal run counter. In TRACK, consecutive mismatching compares increment run (saturating 255); a matching compare resets run to 0; max_burst_o = max run observed, updated same edge as err_cnt_o; cleared by rst/clear_i. Without macro: port and logic absent.

Test Plan:
- Clean loopback, SKIP_BITS=8: push 200 bits, decoder echoes them delayed 20 cycles -> state SKIP then TRACK, bit_cnt_o=192, err_cnt_o=0, no flags.
- Inject 3 flipped decoded bits at TRACK positions 10,11,50 -> err_o pulses exactly 3 times, one cycle after each pop; err_cnt_o=3; with BER_BURST_EN max_burst_o=2.
- Fill FIFO to 64 without pops, push one more -> overflow_o=1, fifo_level_o=64; push+pop same cycle while full -> level stays 64, no further overflow.
- dec_valid_i with empty FIFO -> underflow_o=1, counters unchanged; subsequent push then pop compares normally.
- CNT_W=4, 20 compares all mismatching -> bit_cnt_o=err_cnt_o=15, held.
- clear_i mid-TRACK with 5 bits in FIFO -> counters/flags 0, state IDLE, fifo_level_o=5; rst asserted asynchronously mid-stream -> all outputs 0 without clock edge.
